// File: rtl/bc_control_unit.sv
// Hardwired control unit for the 16-bit basic computer: sequences fetch/decode/execute
// with a 3-bit sequence counter and drives the bus select plus the control-signal array.
module bc_control_unit #(
    parameter int WIDTH      = 16,
    parameter int CTRL_LNGTH = 21
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IR_IN,
    input  logic [WIDTH-1:0] AC_IN,
    input  logic [WIDTH-1:0] DR_IN,
    input  logic             E_IN,
    output logic [2:0]       BUS_SEL,
    output logic [2:0]       CTRL_SGNLS [0:CTRL_LNGTH-1],
    output logic [2:0]       SC_OUT,
    output logic             HALTED,
    output logic             INSTR_DONE
);

    localparam int LD_AR  = 0,  INR_AR = 1,  CLR_AR = 2,  LD_PC  = 3,  INR_PC = 4,
                   CLR_PC = 5,  LD_DR  = 6,  INR_DR = 7,  CLR_DR = 8,  LD_AC  = 9,
                   INR_AC = 10, CLR_AC = 11, LD_IR  = 12, LD_TR  = 13, INR_TR = 14,
                   CLR_TR = 15, MEM_WE = 16, LD_E   = 17, CMP_E  = 18, CLR_E  = 19,
                   OPSEL_ALU = 20;

    typedef enum logic [2:0] {
        BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_TR, BUS_MEM, BUS_ZERO
    } bus_e;

    typedef enum logic [2:0] {
        ALU_AND, ALU_ADD, ALU_PASS_DR, ALU_CMA, ALU_SHR, ALU_SHL
    } alu_e;

    logic                 init_q, halt_q, halt_d;
    logic [2:0]           sc_q, sc_d;
    logic [2:0]           d_q, d_d;
    logic                 i_q, i_d;
    bus_e                 bus;
    alu_e                 opsel;
    logic [OPSEL_ALU-1:0] strb;
    logic                 done;

    // NOTE: every signal gets a default before the case tree so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        bus    = BUS_AR;
        opsel  = ALU_AND;
        strb   = '0;
        done   = 1'b0;
        sc_d   = sc_q;
        d_d    = d_q;
        i_d    = i_q;
        halt_d = halt_q;

        if (halt_q) begin
            sc_d = '0;
        end else if (init_q) begin
            strb[CLR_AR] = 1'b1;
            strb[CLR_PC] = 1'b1;
            strb[CLR_DR] = 1'b1;
            strb[CLR_AC] = 1'b1;
            strb[CLR_TR] = 1'b1;
            strb[CLR_E]  = 1'b1;
            sc_d         = '0;
        end else begin
            sc_d = sc_q + 3'd1;
            case (sc_q)
                3'd0: begin bus = BUS_PC;  strb[LD_AR] = 1'b1; end
                3'd1: begin bus = BUS_MEM; strb[LD_IR] = 1'b1; strb[INR_PC] = 1'b1; end
                3'd2: begin
                    bus         = BUS_IR;
                    strb[LD_AR] = 1'b1;
                    d_d         = IR_IN[14:12];
                    i_d         = IR_IN[15];
                end
                3'd3: begin
                    if (d_q == 3'd7) begin
                        done = 1'b1;
                        // Register reference: only the highest set bit of IR[11:0] acts.
                        if (!i_q) begin
                            priority casez (IR_IN[11:0])
                                12'b1???_????_????: strb[CLR_AC] = 1'b1;
                                12'b01??_????_????: strb[CLR_E]  = 1'b1;
                                12'b001?_????_????: begin strb[LD_AC] = 1'b1; opsel = ALU_CMA; end
                                12'b0001_????_????: strb[CMP_E] = 1'b1;
                                12'b0000_1???_????: begin
                                    strb[LD_AC] = 1'b1; strb[LD_E] = 1'b1; opsel = ALU_SHR;
                                end
                                12'b0000_01??_????: begin
                                    strb[LD_AC] = 1'b1; strb[LD_E] = 1'b1; opsel = ALU_SHL;
                                end
                                12'b0000_001?_????: strb[INR_AC] = 1'b1;
                                12'b0000_0001_????: strb[INR_PC] = ~AC_IN[WIDTH-1];
                                12'b0000_0000_1???: strb[INR_PC] = AC_IN[WIDTH-1];
                                12'b0000_0000_01??: strb[INR_PC] = (AC_IN == '0);
                                12'b0000_0000_001?: strb[INR_PC] = ~E_IN;
                                12'b0000_0000_0001: halt_d = 1'b1;
                                default: ;
                            endcase
                        end
                    end else if (i_q) begin
                        bus         = BUS_MEM;
                        strb[LD_AR] = 1'b1;
                    end
                end
                3'd4: begin
                    case (d_q)
                        3'd0, 3'd1, 3'd2, 3'd6: begin bus = BUS_MEM; strb[LD_DR] = 1'b1; end
                        3'd3: begin bus = BUS_AC; strb[MEM_WE] = 1'b1; done = 1'b1; end
                        3'd4: begin bus = BUS_AR; strb[LD_PC] = 1'b1; done = 1'b1; end
                        3'd5: begin bus = BUS_PC; strb[MEM_WE] = 1'b1; strb[INR_AR] = 1'b1; end
                        default: ;
                    endcase
                end
                3'd5: begin
                    case (d_q)
                        3'd0: begin strb[LD_AC] = 1'b1; opsel = ALU_AND; done = 1'b1; end
                        3'd1: begin
                            strb[LD_AC] = 1'b1; strb[LD_E] = 1'b1; opsel = ALU_ADD; done = 1'b1;
                        end
                        3'd2: begin strb[LD_AC] = 1'b1; opsel = ALU_PASS_DR; done = 1'b1; end
                        3'd5: begin bus = BUS_AR; strb[LD_PC] = 1'b1; done = 1'b1; end
                        3'd6: strb[INR_DR] = 1'b1;
                        default: ;
                    endcase
                end
                3'd6: begin
                    if (d_q == 3'd6) begin
                        bus            = BUS_DR;
                        strb[MEM_WE]   = 1'b1;
                        strb[INR_PC]   = (DR_IN == '0);
                        done           = 1'b1;
                    end
                end
                default: sc_d = '0;
            endcase
            if (done) begin
                sc_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            init_q <= 1'b1;
            halt_q <= 1'b0;
            sc_q   <= '0;
            d_q    <= '0;
            i_q    <= 1'b0;
        end else begin
            init_q <= 1'b0;
            halt_q <= halt_d;
            sc_q   <= sc_d;
            d_q    <= d_d;
            i_q    <= i_d;
        end
    end

    // All outputs are forced low for as long as reset is held.
    always_comb begin
        for (int k = 0; k < CTRL_LNGTH; k++) begin
            CTRL_SGNLS[k] = '0;
        end
        if (RST_N) begin
            for (int k = 0; k < OPSEL_ALU; k++) begin
                CTRL_SGNLS[k] = {2'b00, strb[k]};
            end
            CTRL_SGNLS[OPSEL_ALU] = opsel;
        end
    end

    assign BUS_SEL    = RST_N ? bus : BUS_AR;
    assign SC_OUT     = RST_N ? sc_q : 3'd0;
    assign HALTED     = RST_N & halt_q;
    assign INSTR_DONE = RST_N & done;

endmodule
